// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, register count and register-address type.
// Used by decode, issue, write-back and the register file.
package core_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_wr_en, i_wr_addr    write-back that clears a busy bit
//   i_iss_en, i_iss_addr  issue request that sets a busy bit
//   o_iss_ok_c            issue accepted this cycle (combinational)
//   o_busy                raw busy vector, one bit per register
//   o_busy_cnt            registered count of busy bits
module regfile_busy_tracker #(
    parameter  int unsigned NREGS    = core_pkg::NREGS,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(NREGS),
    localparam int unsigned CW       = $clog2(NREGS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic             i_iss_en,
    input  logic [AW-1:0]    i_iss_addr,
    output logic             o_iss_ok_c,
    output logic [NREGS-1:0] o_busy,
    output logic [CW-1:0]    o_busy_cnt
);

    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_busy_cnt;
    logic [NREGS-1:0] w_busy_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_iss_ok;
    logic             w_set;
    logic             w_clr;
    logic             w_iss_zero;

    assign w_iss_zero = (ZERO_REG != 0) && (i_iss_addr == '0);

    // A pending write-back to the same register frees it in time for a new producer.
    assign w_iss_ok = i_iss_en && (!r_busy[i_iss_addr] || (i_wr_en && (i_wr_addr == i_iss_addr)));
    assign w_set    = w_iss_ok && !w_iss_zero;
    assign w_clr    = i_wr_en && r_busy[i_wr_addr];

    // Clear first, then set, so an issue to the register being written back wins.
    // The set target is never already busy unless it is also being cleared,
    // so the count moves by exactly set - clr.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[i_wr_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[i_iss_addr] = 1'b1;
        end
        w_cnt_nxt = r_busy_cnt + CW'(w_set) - CW'(w_clr);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign o_iss_ok_c = w_iss_ok;
    assign o_busy     = r_busy;
    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and a busy-bit scoreboard.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   rd_addr/rd_data/rd_busy    NRP combinational read ports with RAW hazard flag
//   wr_en/wr_addr/wr_data      write-back port (posedge)
//   iss_en/iss_addr/iss_ok     issue port; iss_ok is combinational
//   busy_cnt                   number of registers currently busy
module regfile_sb #(
    parameter  int unsigned XLEN     = core_pkg::XLEN,
    parameter  int unsigned NREGS    = core_pkg::NREGS,
    parameter  int unsigned NRP      = 2,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(NREGS),
    localparam int unsigned CW       = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ok,
    output logic [CW-1:0]       busy_cnt
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_wr_zero;

    assign w_wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

    regfile_busy_tracker #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .o_iss_ok_c (iss_ok),
        .o_busy     (w_busy),
        .o_busy_cnt (busy_cnt)
    );

    // Data array write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && !w_wr_zero) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: zero register, then write-back bypass, then storage.
    for (genvar k = 0; k < int'(NRP); k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_zero;
        logic          w_byp;

        assign w_addr = rd_addr[k*AW +: AW];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
        assign w_byp  = wr_en && (wr_addr == w_addr);

        assign rd_data[k*XLEN +: XLEN] = w_zero ? '0 : (w_byp ? wr_data : r_regs[w_addr]);
        // The arriving write-back resolves the hazard in the same cycle.
        assign rd_busy[k] = !w_zero && w_busy[w_addr] && !w_byp;
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRP   = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = 6;

    logic                clk;
    logic                rst;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ok;
    logic [CW-1:0]       busy_cnt;

    regfile_sb #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRP      (NRP),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_ok   (iss_ok),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_b0;
        logic        e_b1;
        logic        e_ok;
        logic [5:0]  e_cnt;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] cnt;
    } sb_t;

    localparam int NV = 17;
    vec_t tbl [NV];
    sb_t  sbq [$];
    logic [31:0] model [NREGS];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        rd_addr  = {ra1, ra0};
    endtask

    task automatic push_cnt(input string name, input logic [5:0] cnt);
        sb_t e;
        e.name = name;
        e.cnt  = cnt;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        sb_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: actual=empty required=entry");
        end else begin
            e = sbq.pop_front();
            check(e.name, 32'(busy_cnt), 32'(e.cnt));
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                                input logic e_b0, input logic e_b1, input logic e_ok,
                                input logic [5:0] e_cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        v.e_b0 = e_b0; v.e_b1 = e_b1; v.e_ok = e_ok; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        //             we wa  wd            ie ia  ra0 ra1 rd0           rd1           b0 b1 ok cnt
        tbl[0]  = mk(0, 0,  32'h0,        0, 0,  5,  0,  32'h0,        32'h0,        0, 0, 0, 0);
        tbl[1]  = mk(1, 7,  32'h12345678, 0, 0,  7,  7,  32'h12345678, 32'h12345678, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0,  32'h0,        0, 0,  7,  3,  32'h12345678, 32'h0,        0, 0, 0, 0);
        tbl[3]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,        32'h0,        0, 0, 1, 0);
        tbl[4]  = mk(0, 0,  32'h0,        0, 0,  0,  7,  32'h0,        32'h12345678, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0,  32'h0,        1, 3,  3,  7,  32'h0,        32'h12345678, 0, 0, 1, 1);
        tbl[6]  = mk(0, 0,  32'h0,        1, 3,  3,  7,  32'h0,        32'h12345678, 1, 0, 0, 1);
        tbl[7]  = mk(1, 3,  32'hA5,       0, 0,  3,  3,  32'hA5,       32'hA5,       0, 0, 0, 0);
        tbl[8]  = mk(0, 0,  32'h0,        0, 0,  3,  0,  32'hA5,       32'h0,        0, 0, 0, 0);
        tbl[9]  = mk(0, 0,  32'h0,        1, 9,  9,  3,  32'h0,        32'hA5,       0, 0, 1, 1);
        tbl[10] = mk(1, 9,  32'hCAFE,     1, 9,  9,  9,  32'hCAFE,     32'hCAFE,     0, 0, 1, 1);
        tbl[11] = mk(0, 0,  32'h0,        1, 9,  9,  3,  32'hCAFE,     32'hA5,       1, 0, 0, 1);
        tbl[12] = mk(1, 9,  32'h1,        0, 0,  9,  9,  32'h1,        32'h1,        0, 0, 0, 0);
        tbl[13] = mk(1, 4,  32'h44,       0, 0,  4,  9,  32'h44,       32'h1,        0, 0, 0, 0);
        tbl[14] = mk(1, 3,  32'h33,       1, 4,  3,  4,  32'h33,       32'h44,       0, 0, 1, 1);
        tbl[15] = mk(1, 4,  32'h55,       0, 0,  4,  3,  32'h55,       32'h33,       0, 0, 0, 0);
        tbl[16] = mk(0, 0,  32'h0,        0, 0,  4,  9,  32'h55,       32'h1,        0, 0, 0, 0);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("reset_cnt", 32'(busy_cnt), 32'd0);
        check("reset_busy", 32'(rd_busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Mid-operation asynchronous reset
        drive(1, 5, 32'hDEADBEEF, 1, 6, 5, 6);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 5, 6);
        #1;
        check("pre_rst_rd5", rd_data[31:0], 32'hDEADBEEF);
        check("pre_rst_busy6", 32'(rd_busy[1]), 32'd1);
        check("pre_rst_cnt", 32'(busy_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_rd5", rd_data[31:0], 32'h0);
        check("rst_busy6", 32'(rd_busy[1]), 32'd0);
        check("rst_cnt", 32'(busy_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, tbl[i].ra0, tbl[i].ra1);
            push_cnt($sformatf("cnt_v%0d", i), tbl[i].e_cnt);
            #2;
            check($sformatf("rd0_v%0d", i), rd_data[31:0], tbl[i].e_rd0);
            check($sformatf("rd1_v%0d", i), rd_data[63:32], tbl[i].e_rd1);
            check($sformatf("busy0_v%0d", i), 32'(rd_busy[0]), 32'(tbl[i].e_b0));
            check($sformatf("busy1_v%0d", i), 32'(rd_busy[1]), 32'(tbl[i].e_b1));
            check($sformatf("ok_v%0d", i), 32'(iss_ok), 32'(tbl[i].e_ok));
            @(posedge clk);
            #1;
            pop_check();
        end

        // Saturation: issue x1..x31 back to back
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            drive(0, 0, 0, 1, 5'(r), 5'(r), 0);
            push_cnt($sformatf("sat_up_x%0d", r), 6'(r));
            #2;
            check($sformatf("sat_ok_x%0d", r), 32'(iss_ok), 32'd1);
            @(posedge clk);
            #1;
            pop_check();
        end
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd17, 5'd17, 5'd31);
        #2;
        check("sat_waw_refuse", 32'(iss_ok), 32'd0);
        check("sat_busy17", 32'(rd_busy[0]), 32'd1);
        check("sat_busy31", 32'(rd_busy[1]), 32'd1);

        // Drain: write back every busy register
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            model[r] = 32'h01010101 * 32'(r);
            drive(1, 5'(r), model[r], 0, 0, 5'(r), 0);
            push_cnt($sformatf("sat_dn_x%0d", r), 6'(31 - r));
            #2;
            check($sformatf("drain_byp_busy_x%0d", r), 32'(rd_busy[0]), 32'd0);
            @(posedge clk);
            #1;
            pop_check();
        end

        // Write-back to a non-busy register must not wrap the count
        @(negedge clk);
        model[1] = 32'h0BADF00D;
        drive(1, 5'd1, model[1], 0, 0, 0, 0);
        push_cnt("no_wrap", 6'd0);
        @(posedge clk);
        #1;
        pop_check();

        // Storage read-back of drained registers
        for (int r = 1; r < 32; r += 2) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 5'(r), 5'(r + 1));
            #2;
            check($sformatf("rb_x%0d", r), rd_data[31:0], model[r]);
            if (r + 1 < 32) begin
                check($sformatf("rb_x%0d", r + 1), rd_data[63:32], model[r + 1]);
            end
        end

        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: actual=%0d required=0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated busy-bit scoreboard for the pipelined core. Provides NRP combinational read ports with same-cycle write-back bypass, one posedge write port, and one issue port that marks a destination register busy until its write-back arrives. Sits between decode/issue (read operands, check hazards) and write-back (commit results).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of two, at least 2
- NRP, 2, number of read ports
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
- AW, $clog2(NREGS), derived; not overridden
- CW, $clog2(NREGS+1), derived; not overridden

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NRP*AW  read addresses; port k in bits [k*AW +: AW]
- rd_data  out  NRP*XLEN  read data; port k in bits [k*XLEN +: XLEN]
- rd_busy  out  NRP  1 = operand k still pending (RAW hazard)
- wr_en  in  1  write-back valid
- wr_addr  in  AW  write-back destination
- wr_data  in  XLEN  write-back value
- iss_en  in  1  issue request: mark iss_addr busy
- iss_addr  in  AW  issued destination
- iss_ok  out  1  issue accepted this cycle (combinational)
- busy_cnt  out  CW  number of registers currently busy

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits.
- Write: on a clk edge with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0. With ZERO_REG=1 and wr_addr=0, no effect.
- Read port k, combinational, in priority order:
  - rd_addr=0 and ZERO_REG=1 -> 0
  - wr_en=1 and wr_addr=rd_addr -> wr_data (bypass)
  - otherwise regs[rd_addr]
- rd_busy[k] = busy[rd_addr] and not (wr_en and wr_addr=rd_addr); 0 for reg 0 when ZERO_REG=1.
- iss_ok = iss_en and (busy[iss_addr]=0 or (wr_en and wr_addr=iss_addr)). This refuses a second outstanding producer (WAW).
- On a clk edge with iss_ok=1: busy[iss_addr] <= 1. Issue to reg 0 with ZERO_REG=1 gives iss_ok=1 but sets no bit.
- Same register written back and issued in one cycle: data is written and the busy bit ends at 1 (issue wins).
- Refused issue (iss_en=1, iss_ok=0) changes no state. The requester holds its request and retries.
- busy_cnt is a registered population count of busy bits:
  - +1 on an accepted issue that sets a bit
  - -1 on a write-back that clears a set bit
  - net 0 when both act on the same register
  - never wraps: a maximum of NREGS-ZERO_REG is reachable, and CW bits hold it
- Write-back to a non-busy register is legal: data updates and busy stays 0.

## Timing
- Reset (rst=1, asynchronous): all registers 0, all busy bits 0, busy_cnt=0. Outputs follow immediately: rd_data=0, rd_busy=0.
- Reset asserted mid-operation discards all pending busy state and data in the same instant. The first edge after deassertion behaves as a normal cycle.
- Read latency 0; write-to-read visible the same cycle via bypass and from storage after the edge.
- Issue-to-busy latency: one edge. rd_busy for that register rises in the cycle after iss_ok.
- iss_ok, rd_data and rd_busy are purely combinational from current inputs and state, so they must not feed back into iss_en or wr_en within the same cycle.

## Structure
- Shared package core_pkg: XLEN, NREGS and the register-address type, reused by decode and write-back.
- One sub-module: regfile_busy_tracker. It holds the busy bits and busy_cnt, and produces iss_ok and the raw busy vector.
- The top level holds the data array, read muxing and bypass logic.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert rst -> rd_data(x5)=0, busy_cnt=0, all rd_busy=0 with no clock edge.
- Bypass: wr_en=1, wr_addr=7, wr_data=0x1234_5678, rd_addr[0]=7 in the same cycle -> rd_data[0]=0x12345678 before the edge; after the edge, reading with wr_en=0 still returns 0x12345678.
- Zero register: write 0xFFFFFFFF to x0 and issue x0 -> rd_data=0, rd_busy=0, busy_cnt stays 0.
- Scoreboard: issue x3 -> next cycle rd_busy(x3)=1 and busy_cnt=1. Issue x3 again -> iss_ok=0. Write back x3=0xA5 -> same cycle rd_busy=0 and rd_data=0xA5; next cycle busy_cnt=0.
- Simultaneous events: x9 busy; wr_en to x9 and iss_en to x9 in one cycle -> iss_ok=1, x9 holds the new data, busy(x9)=1, busy_cnt unchanged at 1.
- Saturation: issue x1 through x31 on consecutive cycles -> busy_cnt=31. Write back all of them -> busy_cnt=0, no wrap.
